washer_panel: RTL and testbench
===============================

WASHER_PANEL -- requirements
Module: washer_panel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, is the number of consecutive stable synchronized samples required to accept a level change; legal range is >= 1.
REQ-002 Parameter REPEAT_DELAY, default 200, is the number of cycles from the in_click press pulse to the first auto-repeat pulse; legal range is >= 2.
REQ-003 Parameter REPEAT_PERIOD, default 50, is the number of cycles between successive auto-repeat pulses; legal range is >= 2.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 in_resetBtn  input  1  asynchronous, active-low reset.
REQ-006 raw_runBtn, raw_WaterBtn, raw_openBtn, raw_click  input  1 each  raw mechanical panel contacts, asynchronous to clk, may bounce.
REQ-007 in_runBtn  output  1  debounced level of raw_runBtn (run switch).
REQ-008 in_openBtn  output  1  debounced level of raw_openBtn (door switch).
REQ-009 in_WaterBtn  output  1  single-cycle pulse per accepted press of raw_WaterBtn.
REQ-010 in_click  output  1  single-cycle pulse per accepted press of raw_click, plus auto-repeat pulses while held.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL run an independent 4-state debounce FSM with states STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW.
REQ-013 The channel SHALL move STABLE_LOW->WAIT_HIGH when the synchronized sample is 1, and clear its counter on that transition.
REQ-014 In WAIT_HIGH the counter SHALL increment each cycle the sample is 1; a sample of 0 SHALL return the channel to STABLE_LOW with the counter cleared.
REQ-015 In WAIT_HIGH, when the counter reaches DEBOUNCE_CYCLES, the channel SHALL enter STABLE_HIGH and the debounced level SHALL become 1.
REQ-016 STABLE_HIGH->WAIT_LOW->STABLE_LOW SHALL behave symmetrically to REQ-013..REQ-015 with 0 and 1 swapped.
REQ-017 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), and the counter SHALL saturate without wrapping.
REQ-018 Latency: a clean raw transition first sampled at edge N SHALL change the debounced level at edge N+2+DEBOUNCE_CYCLES.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no output change.
REQ-020 in_runBtn and in_openBtn SHALL equal the registered debounced level of their channels.
REQ-021 in_WaterBtn and in_click SHALL be high for exactly one cycle, on the edge where the debounced level goes 0->1; a release SHALL generate no pulse.
REQ-022 At the press pulse, a repeat timer for click SHALL be cleared to 0 and SHALL then increment each cycle while the click debounced level is 1.
REQ-023 When the repeat timer equals REPEAT_DELAY, in_click SHALL pulse and the timer SHALL reload to REPEAT_DELAY-REPEAT_PERIOD, giving a further pulse every REPEAT_PERIOD cycles.
REQ-024 When the click debounced level falls, the repeat timer SHALL clear and no further pulses SHALL be issued; a pulse due on the falling edge's cycle SHALL be suppressed.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL be processed in the same cycles.
REQ-026 in_WaterBtn SHALL NOT auto-repeat.

Reset
REQ-027 While in_resetBtn=0, and asynchronously upon its assertion, all synchronizers, counters and timers SHALL be 0, all FSMs SHALL be in STABLE_LOW, and all four outputs SHALL be 0.
REQ-028 A reset asserted mid-debounce or mid-repeat SHALL discard all pending progress.
REQ-029 After reset release, a raw input already held at 1 SHALL be treated as a new press (REQ-018 timing measured from the first edge after release).

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; edge 0 is the first sampling edge)
REQ-030 raw_click 0->1 held 8 cycles, then 0 -> exactly one in_click pulse, at edge 6, and no pulse on release.
REQ-031 raw_WaterBtn toggles every 2 cycles for 12 cycles, then held at 1 from edge 12 -> no pulse before edge 18; exactly one pulse at edge 18.
REQ-032 raw_runBtn 1 at edge 0, 0 for 3 cycles at edges 20-22, 0 from edge 40 -> in_runBtn rises at edge 6, has no dip, and falls at edge 46.
REQ-033 raw_click held at 1 for edges 0-29 -> in_click pulses at edges 6, 16, 19, 22, 25, 28, 31, 34 (8 pulses); none thereafter.
REQ-034 Reset asserted at edge 5 with raw_openBtn high since edge 0, released before edge 10 -> in_openBtn is 0 immediately on assertion and rises at edge 16.
REQ-035 All four raw inputs rise at edge 0 -> in_runBtn and in_openBtn rise, and in_WaterBtn and in_click pulse, all at edge 6.

Source files
------------

// File: rtl/washer_panel.sv
// rtl/washer_panel.sv - washer control panel input conditioning: sync, debounce, press pulses, click auto-repeat
// Four raw contacts in, two debounced levels and two press pulses out.

module washer_panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    output logic level_o,
    output logic level_next_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          level_q, level_d;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // The accepting edge is the one on which the count reaches DEBOUNCE_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE_LOW: begin
                if (sample_i) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sample_i) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = STABLE_HIGH;
                        level_d = 1'b1;
                    end
                end
            end
            STABLE_HIGH: begin
                if (!sample_i) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sample_i) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = STABLE_LOW;
                        level_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;
endmodule

module washer_panel #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 200,
    parameter int REPEAT_PERIOD   = 50
) (
    input  logic clk,
    input  logic in_resetBtn,
    input  logic raw_runBtn,
    input  logic raw_WaterBtn,
    input  logic raw_openBtn,
    input  logic raw_click,
    output logic in_runBtn,
    output logic in_openBtn,
    output logic in_WaterBtn,
    output logic in_click
);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_HIT    = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    // Channel order: 0 run, 1 water, 2 open, 3 click.
    logic [3:0] raw_vec;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] level_q, level_d;

    logic          water_pulse_q, water_pulse_d;
    logic          click_pulse_q, click_pulse_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic [RW-1:0] rpt_inc;

    assign raw_vec = {raw_click, raw_openBtn, raw_WaterBtn, raw_runBtn};

    always_ff @(posedge clk or negedge in_resetBtn) begin
        if (!in_resetBtn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_vec;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        washer_panel_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk         (clk),
            .rst_n       (in_resetBtn),
            .sample_i    (sync2_q[i]),
            .level_o     (level_q[i]),
            .level_next_o(level_d[i])
        );
    end

    assign rpt_inc = (rpt_q == RPT_HIT) ? rpt_q : rpt_q + 1'b1;

    // Pulses are registered on the same edge the debounced level rises.
    // A repeat due on the release edge is dropped because level_d is already 0.
    always_comb begin
        water_pulse_d = level_d[1] & ~level_q[1];
        click_pulse_d = 1'b0;
        rpt_d         = '0;
        if (level_d[3] && !level_q[3]) begin
            click_pulse_d = 1'b1;
        end else if (level_d[3]) begin
            if (rpt_inc == RPT_HIT) begin
                click_pulse_d = 1'b1;
                rpt_d         = RPT_RELOAD;
            end else begin
                rpt_d = rpt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge in_resetBtn) begin
        if (!in_resetBtn) begin
            water_pulse_q <= 1'b0;
            click_pulse_q <= 1'b0;
            rpt_q         <= '0;
        end else begin
            water_pulse_q <= water_pulse_d;
            click_pulse_q <= click_pulse_d;
            rpt_q         <= rpt_d;
        end
    end

    assign in_runBtn   = level_q[0];
    assign in_openBtn  = level_q[2];
    assign in_WaterBtn = water_pulse_q;
    assign in_click    = click_pulse_q;
endmodule

// File: tb/tb_washer_panel.sv
// tb/tb_washer_panel.sv - directed bench for washer_panel with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3

module tb_washer_panel;
    logic clk = 1'b0;
    logic in_resetBtn;
    logic raw_runBtn, raw_WaterBtn, raw_openBtn, raw_click;
    logic in_runBtn, in_openBtn, in_WaterBtn, in_click;

    int n_checks = 0;
    int n_fail   = 0;

    washer_panel #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk         (clk),
        .in_resetBtn (in_resetBtn),
        .raw_runBtn  (raw_runBtn),
        .raw_WaterBtn(raw_WaterBtn),
        .raw_openBtn (raw_openBtn),
        .raw_click   (raw_click),
        .in_runBtn   (in_runBtn),
        .in_openBtn  (in_openBtn),
        .in_WaterBtn (in_WaterBtn),
        .in_click    (in_click)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, checks the reset state, releases between edges.
    // The next edge after return is edge 0.
    task automatic do_reset();
        in_resetBtn  = 1'b0;
        raw_runBtn   = 1'b0;
        raw_WaterBtn = 1'b0;
        raw_openBtn  = 1'b0;
        raw_click    = 1'b0;
        tick();
        tick();
        check("rst_run",   -1, in_runBtn,   1'b0);
        check("rst_open",  -1, in_openBtn,  1'b0);
        check("rst_water", -1, in_WaterBtn, 1'b0);
        check("rst_click", -1, in_click,    1'b0);
        in_resetBtn = 1'b1;
    endtask

    initial begin
        // Single press held 8 cycles: one pulse at edge 6, none on release.
        do_reset();
        for (int k = 0; k < 25; k++) begin
            raw_click = (k < 8);
            tick();
            check("click_single", k, in_click, k == 6);
        end

        // Bouncing water button, then steady from edge 12: one pulse at 18.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            raw_WaterBtn = (k >= 12) ? 1'b1 : (((k / 2) % 2) == 0);
            tick();
            check("water_bounce", k, in_WaterBtn, k == 18);
        end

        // Run switch with a 3-cycle dropout that must be filtered.
        do_reset();
        for (int k = 0; k < 56; k++) begin
            raw_runBtn = !(k >= 20 && k <= 22) && (k < 40);
            tick();
            check("run_level", k, in_runBtn, (k >= 6) && (k < 46));
        end

        // Held click: press pulse, first repeat after 10, then every 3, stop on release.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            raw_click = (k < 30);
            tick();
            check("click_repeat", k, in_click,
                  (k == 6) || (k == 16) || (k == 19) || (k == 22) ||
                  (k == 25) || (k == 28) || (k == 31) || (k == 34));
        end

        // Reset mid-debounce on the door switch discards progress.
        do_reset();
        raw_openBtn = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            if (k == 5) begin
                #1;
                in_resetBtn = 1'b0;
                #1;
            end
            if (k == 9) in_resetBtn = 1'b1;
            check("open_reset", k, in_openBtn, k >= 16);
        end

        // All channels at once; water must not repeat while click does.
        do_reset();
        raw_runBtn   = 1'b1;
        raw_WaterBtn = 1'b1;
        raw_openBtn  = 1'b1;
        raw_click    = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            check("all_run",   k, in_runBtn,   k >= 6);
            check("all_open",  k, in_openBtn,  k >= 6);
            check("all_water", k, in_WaterBtn, k == 6);
            check("all_click", k, in_click,    (k == 6) || (k == 16) || (k == 19));
        end

        // Asynchronous reset clears held levels before the next edge.
        #2;
        in_resetBtn = 1'b0;
        #1;
        check("async_run",  -1, in_runBtn,  1'b0);
        check("async_open", -1, in_openBtn, 1'b0);
        tick();
        check("async_click", -1, in_click,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
